// File: rtl/ecc_pkg.sv
// ecc_pkg: shared SECDED Hamming helpers and scrubber types.
//   get_par_width(d) : Hamming check bits needed for d data bits
//   get_cw_width(d)  : Hamming codeword width (data + check bits).
//                      The stored word adds one overall-parity bit at index 0.
//   get_aw(n)        : address width for n words (minimum 1)
//   scrub_state_e    : scrubber FSM states
package ecc_pkg;

   function automatic int unsigned get_par_width(input int unsigned data_width);
      int unsigned r;
      r = 1;
      while ((32'd1 << r) < data_width + r + 1) r++;
      return r;
   endfunction

   function automatic int unsigned get_cw_width(input int unsigned data_width);
      return data_width + get_par_width(data_width);
   endfunction

   function automatic int unsigned get_aw(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_WRITE
   } scrub_state_e;

endpackage

// File: rtl/ecc_decode.sv
// ecc_decode: combinational SECDED decoder.
//   cw_i         : encoded word (layout as in ecc_encode)
//   data_o       : corrected data (valid unless double_err_o)
//   single_err_o : a single-bit error was corrected (data or check bit,
//                  including the overall-parity bit)
//   double_err_o : the error is not correctable
module ecc_decode
   import ecc_pkg::*;
#(
   parameter int unsigned DataWidth = 32,
   localparam int unsigned CW = get_cw_width(DataWidth),
   localparam int unsigned PW = get_par_width(DataWidth)
) (
   input  logic [CW:0]          cw_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 single_err_o,
   output logic                 double_err_o
);

   logic [PW-1:0] syn;
   logic          par;
   logic [CW:0]   fixed;

   always_comb begin
      syn = '0;
      for (int unsigned p = 1; p <= CW; p++) begin
         if (cw_i[p]) syn = syn ^ PW'(p);
      end
      par   = ^cw_i;
      fixed = cw_i;
      for (int unsigned p = 1; p <= CW; p++) begin
         if (syn == PW'(p)) fixed[p] = ~fixed[p];
      end
      data_o = '0;
      for (int unsigned p = 3; p <= CW; p++) begin
         if ((p & (p - 1)) != 0) data_o[p - 1 - $clog2(p + 1)] = fixed[p];
      end
      // Odd parity with a syndrome that points outside the codeword is not
      // a real single error.
      single_err_o = par && (32'(syn) <= CW);
      double_err_o = (!par && (syn != '0)) || (par && (32'(syn) > CW));
   end

endmodule

// File: rtl/ecc_encode.sv
// ecc_encode: combinational SECDED encoder.
//   data_i : DataWidth data bits
//   cw_o   : encoded word. Bit 0 is overall parity, and bits 1..CW are
//            Hamming positions. Check bits sit at the power-of-two positions;
//            data fills the remaining positions in ascending order.
module ecc_encode
   import ecc_pkg::*;
#(
   parameter int unsigned DataWidth = 32,
   localparam int unsigned CW = get_cw_width(DataWidth),
   localparam int unsigned PW = get_par_width(DataWidth)
) (
   input  logic [DataWidth-1:0] data_i,
   output logic [CW:0]          cw_o
);

   logic [CW:0]   pos;
   logic [PW-1:0] par;

   always_comb begin
      pos = '0;
      // Data bit index = position - 1 - (number of powers of two <= position).
      for (int unsigned p = 3; p <= CW; p++) begin
         if ((p & (p - 1)) != 0) pos[p] = data_i[p - 1 - $clog2(p + 1)];
      end
      par = '0;
      for (int unsigned k = 0; k < PW; k++) begin
         for (int unsigned p = 1; p <= CW; p++) begin
            if (((p >> k) & 32'd1) != 0) par[k] = par[k] ^ pos[p];
         end
      end
      cw_o = pos;
      for (int unsigned k = 0; k < PW; k++) cw_o[1 << k] = par[k];
      cw_o[0] = (^pos) ^ (^par);
   end

endmodule

// File: rtl/ecc_sram_scrubber.sv
// ecc_sram_scrubber: walks an ECC-protected SRAM and reads each word in turn.
// A correctable word is written back re-encoded. An uncorrectable word is
// counted and reported.
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   enable_i           : allow scrubbing
//   cnt_clear_i        : zero both error counters
//   scrub_*            : request/grant SRAM port. Read data returns on
//                        scrub_rvalid_i one or more cycles after the grant.
//   func_we_i/addr_i   : functional write that the SRAM accepted this cycle
//   single_cnt_o       : corrected errors (saturating)
//   double_cnt_o       : uncorrectable errors (saturating)
//   double_err_o       : one-cycle pulse for an uncorrectable error
//   double_addr_o      : address of the last uncorrectable error
//   pass_done_o        : one-cycle pulse after the last address is done
//   busy_o             : FSM not idle
module ecc_sram_scrubber
   import ecc_pkg::*;
#(
   parameter int unsigned NumWords  = 256,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned CntWidth  = 16,
   parameter int unsigned Interval  = 16,
   localparam int unsigned AW = get_aw(NumWords),
   localparam int unsigned EW = get_cw_width(DataWidth) + 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                enable_i,
   input  logic                cnt_clear_i,
   output logic                scrub_req_o,
   output logic                scrub_we_o,
   output logic [AW-1:0]       scrub_addr_o,
   output logic [EW-1:0]       scrub_wdata_o,
   input  logic                scrub_gnt_i,
   input  logic                scrub_rvalid_i,
   input  logic [EW-1:0]       scrub_rdata_i,
   input  logic                func_we_i,
   input  logic [AW-1:0]       func_addr_i,
   output logic [CntWidth-1:0] single_cnt_o,
   output logic [CntWidth-1:0] double_cnt_o,
   output logic                double_err_o,
   output logic [AW-1:0]       double_addr_o,
   output logic                pass_done_o,
   output logic                busy_o
);

   localparam int unsigned   IW       = get_aw(Interval + 1);
   localparam logic [AW-1:0] LastAddr = AW'(NumWords - 1);
   localparam logic [IW-1:0] Reload   = IW'(Interval);

   scrub_state_e         state_q;
   logic [AW-1:0]        addr_q, dbl_addr_q;
   logic [IW-1:0]        ivl_q;
   logic                 stale_q, dbl_err_q, pass_q;
   logic [DataWidth-1:0] wdata_q, dec_data;
   logic [CntWidth-1:0]  single_q, single_d, double_q, double_d;
   logic                 dec_single, dec_double;
   logic                 hit, rd_done, single_inc, double_inc, word_done;

   ecc_decode #(.DataWidth(DataWidth)) u_dec (
      .cw_i         (scrub_rdata_i),
      .data_o       (dec_data),
      .single_err_o (dec_single),
      .double_err_o (dec_double)
   );

   ecc_encode #(.DataWidth(DataWidth)) u_enc (
      .data_i (wdata_q),
      .cw_o   (scrub_wdata_o)
   );

   always_comb begin
      // A functional write to the word in flight makes the read data stale.
      hit = func_we_i && (func_addr_i == addr_q) &&
            ((state_q == ST_WAIT) || (state_q == ST_WRITE) ||
             ((state_q == ST_READ) && scrub_gnt_i));
      rd_done    = (state_q == ST_WAIT) && scrub_rvalid_i;
      single_inc = rd_done && dec_single;
      double_inc = rd_done && dec_double;
      word_done  = (rd_done && (dec_double || !dec_single || stale_q || hit)) ||
                   ((state_q == ST_WRITE) && (scrub_gnt_i || hit));
   end

   always_comb begin
      single_d = single_q;
      if (cnt_clear_i)                           single_d = CntWidth'(single_inc);
      else if (single_inc && (single_q != '1))   single_d = single_q + 1'b1;
      double_d = double_q;
      if (cnt_clear_i)                           double_d = CntWidth'(double_inc);
      else if (double_inc && (double_q != '1))   double_d = double_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         ivl_q      <= '0;
         stale_q    <= 1'b0;
         single_q   <= '0;
         double_q   <= '0;
         dbl_err_q  <= 1'b0;
         dbl_addr_q <= '0;
         pass_q     <= 1'b0;
         wdata_q    <= '0;
      end else begin
         single_q  <= single_d;
         double_q  <= double_d;
         dbl_err_q <= double_inc;
         pass_q    <= 1'b0;
         if (double_inc) dbl_addr_q <= addr_q;
         if (rd_done)    wdata_q    <= dec_data;
         case (state_q)
            ST_IDLE: begin
               if (ivl_q != '0)   ivl_q   <= ivl_q - 1'b1;
               else if (enable_i) state_q <= ST_READ;
            end
            ST_READ: begin
               if (scrub_gnt_i) begin
                  state_q <= ST_WAIT;
                  stale_q <= hit;
               end
            end
            ST_WAIT: begin
               if (hit) stale_q <= 1'b1;
               if (rd_done && !word_done) state_q <= ST_WRITE;
            end
            ST_WRITE: ;
            default: state_q <= ST_IDLE;
         endcase
         if (word_done) begin
            stale_q <= 1'b0;
            addr_q  <= (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
            pass_q  <= (addr_q == LastAddr);
            ivl_q   <= Reload;
            // With no interval the next read issues straight away, so it
            // starts one cycle after the response.
            state_q <= ((Interval == 0) && enable_i) ? ST_READ : ST_IDLE;
         end
      end
   end

   assign scrub_req_o   = (state_q == ST_READ) || (state_q == ST_WRITE);
   assign scrub_we_o    = (state_q == ST_WRITE);
   assign scrub_addr_o  = addr_q;
   assign single_cnt_o  = single_q;
   assign double_cnt_o  = double_q;
   assign double_err_o  = dbl_err_q;
   assign double_addr_o = dbl_addr_q;
   assign pass_done_o   = pass_q;
   assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ecc_sram_scrubber.sv
// Bench for ecc_sram_scrubber: a 4-word SRAM model with a 32-bit SECDED layout.
// Expected write-backs and double-error addresses are queued when the memory
// is corrupted, and they are popped when the DUT produces them.
module tb_ecc_sram_scrubber;

   localparam int NW   = 4;
   localparam int DW   = 32;
   localparam int CW   = 38;
   localparam int EW   = 39;
   localparam int AW   = 2;
   localparam int CNTW = 2;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [EW-1:0] data;
   } wr_t;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b1;
   logic            enable_i = 1'b0;
   logic            cnt_clear_i = 1'b0;
   logic            scrub_req_o, scrub_we_o;
   logic [AW-1:0]   scrub_addr_o;
   logic [EW-1:0]   scrub_wdata_o;
   logic            scrub_gnt_i;
   logic            scrub_rvalid_i = 1'b0;
   logic [EW-1:0]   scrub_rdata_i = '0;
   logic            func_we_i = 1'b0;
   logic [AW-1:0]   func_addr_i = '0;
   logic [CNTW-1:0] single_cnt_o, double_cnt_o;
   logic            double_err_o, pass_done_o, busy_o;
   logic [AW-1:0]   double_addr_o;

   logic            gnt_en = 1'b1;
   int              rd_lat = 1;
   logic [EW-1:0]   mem [NW];
   logic [DW-1:0]   dat [NW];
   wr_t             wq[$];
   int              dq[$];
   int              n_checks = 0, n_errors = 0;
   int              n_rd = 0, n_pass = 0, n_dbl = 0;
   int              exp_rd_addr = 0;
   logic            pend = 1'b0;
   int              pcnt = 0;
   logic [AW-1:0]   paddr = '0;

   always #5 clk_i = ~clk_i;

   assign scrub_gnt_i = scrub_req_o & gnt_en;

   ecc_sram_scrubber #(
      .NumWords (NW),
      .DataWidth(DW),
      .CntWidth (CNTW),
      .Interval (0)
   ) dut (
      .clk_i, .rst_i, .enable_i, .cnt_clear_i,
      .scrub_req_o, .scrub_we_o, .scrub_addr_o, .scrub_wdata_o,
      .scrub_gnt_i, .scrub_rvalid_i, .scrub_rdata_i,
      .func_we_i, .func_addr_i,
      .single_cnt_o, .double_cnt_o, .double_err_o, .double_addr_o,
      .pass_done_o, .busy_o
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference SECDED encoder: bit 0 overall parity, Hamming positions 1..CW.
   function automatic logic [EW-1:0] enc(input logic [DW-1:0] d);
      logic [EW-1:0] c;
      logic          b;
      int            j;
      c = '0;
      j = 0;
      for (int p = 1; p <= CW; p++) begin
         if ((p & (p - 1)) != 0) begin
            c[p] = d[j];
            j++;
         end
      end
      for (int k = 0; k < 6; k++) begin
         b = 1'b0;
         for (int p = 1; p <= CW; p++) if ((p & (1 << k)) != 0) b ^= c[p];
         c[1 << k] = b;
      end
      c[0] = ^c[EW-1:1];
      return c;
   endfunction

   function automatic logic [EW-1:0] bit_at(input int i);
      logic [EW-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // SRAM model: read data after rd_lat cycles; granted writes update mem.
   always @(posedge clk_i) begin
      if (rst_i) begin
         scrub_rvalid_i <= 1'b0;
         pend <= 1'b0;
      end else begin
         scrub_rvalid_i <= 1'b0;
         if (pend) begin
            if (pcnt <= 1) begin
               scrub_rvalid_i <= 1'b1;
               scrub_rdata_i  <= mem[paddr];
               pend <= 1'b0;
            end else pcnt <= pcnt - 1;
         end
         if (scrub_req_o && scrub_gnt_i && !scrub_we_o) begin
            if (rd_lat <= 1) begin
               scrub_rvalid_i <= 1'b1;
               scrub_rdata_i  <= mem[scrub_addr_o];
            end else begin
               pend  <= 1'b1;
               pcnt  <= rd_lat - 1;
               paddr <= scrub_addr_o;
            end
         end
         if (scrub_req_o && scrub_gnt_i && scrub_we_o) mem[scrub_addr_o] = scrub_wdata_o;
      end
   end

   // Monitor: read order, write-backs and double-error reports.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (scrub_req_o && scrub_gnt_i && !scrub_we_o) begin
            check_eq("rd_addr", scrub_addr_o, exp_rd_addr);
            exp_rd_addr = (exp_rd_addr + 1) % NW;
            n_rd++;
         end
         if (scrub_req_o && scrub_gnt_i && scrub_we_o) begin
            check_eq("wr_expected", wq.size() != 0, 1);
            if (wq.size() != 0) begin
               wr_t e;
               e = wq.pop_front();
               check_eq("wr_addr", scrub_addr_o, e.addr);
               check_eq("wr_data", scrub_wdata_o, e.data);
            end
         end
         if (double_err_o) begin
            n_dbl++;
            check_eq("dbl_expected", dq.size() != 0, 1);
            if (dq.size() != 0) check_eq("dbl_addr", double_addr_o, dq.pop_front());
         end
         if (pass_done_o) n_pass++;
      end
   end

   task automatic push_wr(input int a);
      wr_t e;
      e.addr = AW'(a);
      e.data = enc(dat[a]);
      wq.push_back(e);
   endtask

   task automatic clear_cnt();
      @(posedge clk_i); #1 cnt_clear_i = 1'b1;
      @(posedge clk_i); #1 cnt_clear_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int cyc;
      cyc = 0;
      while (busy_o && cyc < 50) begin
         @(negedge clk_i);
         cyc++;
      end
      check_eq(tag, busy_o, 0);
   endtask

   // One pass from address 0. Enable drops once the last read is granted.
   // The functional write to fhit and the counter clear on chit land in the
   // cycle after that word's read grant, which is the response cycle when
   // rd_lat is 1.
   task automatic run_pass(input int fhit, input int chit);
      int cyc;
      bit seen, fire_f, fire_c;
      seen = 0; fire_f = 0; fire_c = 0; cyc = 0;
      n_rd = 0; n_pass = 0; n_dbl = 0;
      enable_i = 1'b1;
      while (!seen && cyc < 300) begin
         @(posedge clk_i); #1;
         func_we_i   = fire_f;
         cnt_clear_i = fire_c;
         if (fire_f) begin
            func_addr_i = AW'(fhit);
            dat[fhit] = $urandom;
            mem[fhit] = enc(dat[fhit]);
         end
         @(negedge clk_i);
         fire_f = scrub_req_o && scrub_gnt_i && !scrub_we_o && (scrub_addr_o == fhit);
         fire_c = scrub_req_o && scrub_gnt_i && !scrub_we_o && (scrub_addr_o == chit);
         if (scrub_req_o && scrub_gnt_i && !scrub_we_o && (scrub_addr_o == NW - 1)) enable_i = 1'b0;
         if (pass_done_o) seen = 1;
         cyc++;
      end
      enable_i = 1'b0;
      @(posedge clk_i); #1;
      func_we_i = 1'b0;
      cnt_clear_i = 1'b0;
      check_eq("pass_seen", seen, 1);
      wait_idle("pass_idle");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NW; i++) begin
         dat[i] = $urandom;
         mem[i] = enc(dat[i]);
      end
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      check_eq("rst_req", scrub_req_o, 0);
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_single", single_cnt_o, 0);
      check_eq("rst_double", double_cnt_o, 0);
      check_eq("rst_daddr", double_addr_o, 0);
      check_eq("rst_pulses", {pass_done_o, double_err_o}, 0);

      // Clean pass with multi-cycle read latency.
      rd_lat = 3;
      run_pass(-1, -1);
      check_eq("clean_reads", n_rd, 4);
      check_eq("clean_pass", n_pass, 1);
      check_eq("clean_single", single_cnt_o, 0);
      check_eq("clean_double", double_cnt_o, 0);
      rd_lat = 1;

      // Data bit 5 (Hamming position 10) flipped at address 2.
      clear_cnt();
      mem[2] = enc(dat[2]) ^ bit_at(10);
      push_wr(2);
      run_pass(-1, -1);
      check_eq("se_single", single_cnt_o, 1);
      check_eq("se_double", double_cnt_o, 0);
      check_eq("se_wq_left", wq.size(), 0);

      // Two bits flipped at address 1.
      clear_cnt();
      mem[1] = enc(dat[1]) ^ bit_at(3) ^ bit_at(20);
      dq.push_back(1);
      run_pass(-1, -1);
      check_eq("de_double", double_cnt_o, 1);
      check_eq("de_single", single_cnt_o, 0);
      check_eq("de_pulses", n_dbl, 1);
      check_eq("de_addr", double_addr_o, 1);
      check_eq("de_dq_left", dq.size(), 0);
      mem[1] = enc(dat[1]);

      // Single error at address 3 overwritten functionally during the read.
      clear_cnt();
      mem[3] = enc(dat[3]) ^ bit_at(7);
      run_pass(3, -1);
      check_eq("stale_single", single_cnt_o, 1);
      check_eq("stale_wq_left", wq.size(), 0);

      // Four single errors saturate the 2-bit counter.
      clear_cnt();
      for (int i = 0; i < NW; i++) begin
         mem[i] = enc(dat[i]) ^ bit_at(12 + i);
         push_wr(i);
      end
      run_pass(-1, -1);
      check_eq("sat_single", single_cnt_o, 3);
      check_eq("sat_wq_left", wq.size(), 0);

      // Clear in the same cycle as a counted error leaves the count at 1.
      mem[0] = enc(dat[0]) ^ bit_at(30);
      push_wr(0);
      run_pass(-1, 0);
      check_eq("clr_inc_single", single_cnt_o, 1);
      check_eq("clr_inc_double", double_cnt_o, 0);
      check_eq("clr_wq_left", wq.size(), 0);

      // Grant withheld and enable dropped while the read is pending.
      gnt_en = 1'b0;
      @(posedge clk_i); #1 enable_i = 1'b1;
      begin
         int cyc;
         cyc = 0;
         do begin
            @(negedge clk_i);
            cyc++;
         end while (!scrub_req_o && cyc < 20);
      end
      enable_i = 1'b0;
      repeat (5) begin
         @(negedge clk_i);
         check_eq("hold_req", scrub_req_o, 1);
      end
      gnt_en = 1'b1;
      wait_idle("hold_idle");
      check_eq("hold_req_off", scrub_req_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ecc_sram_scrubber.md
ECC_SRAM_SCRUBBER -- requirements
Module: ecc_sram_scrubber

Interface
REQ-001 SHALL have parameter NumWords, default 256: number of encoded words in the scrubbed SRAM (minimum 2).
REQ-002 SHALL have parameter DataWidth, default 32: unencoded data width; encoded word width EW = get_cw_width(DataWidth)+1 from ecc_pkg.
REQ-003 SHALL have parameter CntWidth, default 16: error counter width.
REQ-004 SHALL have parameter Interval, default 16: idle cycles between scrubbed words; 0 = back-to-back.
REQ-005 SHALL have ports: clk_i in 1 clock; rst_i in 1 asynchronous active-high reset; one clock, no other clock domain.
REQ-006 SHALL have ports: enable_i in 1 scrubbing enable; cnt_clear_i in 1 clear both counters.
REQ-007 SHALL have ports: scrub_req_o out 1; scrub_we_o out 1; scrub_addr_o out AW=$clog2(NumWords); scrub_wdata_o out EW; scrub_gnt_i in 1; scrub_rvalid_i in 1; scrub_rdata_i in EW.
REQ-008 SHALL have ports: func_we_i in 1 functional write accepted by SRAM this cycle; func_addr_i in AW its address.
REQ-009 SHALL have ports: single_cnt_o out CntWidth corrected errors (single or parity); double_cnt_o out CntWidth uncorrectable errors; double_err_o out 1 one-cycle pulse; double_addr_o out AW address of last double error; pass_done_o out 1 one-cycle pulse; busy_o out 1 FSM not in IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, READ, WAIT, WRITE; busy_o = (state != IDLE).
REQ-011 IDLE: interval counter decrements to 0; IDLE->READ when enable_i=1 and counter=0.
REQ-012 READ: scrub_req_o=1, scrub_we_o=0, scrub_addr_o=addr_q; READ->WAIT on scrub_gnt_i; request SHALL NOT be withdrawn before grant, even if enable_i falls.
REQ-013 WAIT: on scrub_rvalid_i (any latency >=1 cycle after grant) decode scrub_rdata_i; single or parity error -> increment single_cnt, go WRITE unless stale; double error -> increment double_cnt, pulse double_err_o next cycle, load double_addr_o=addr_q, no write-back; no error -> word done.
REQ-014 WRITE: scrub_req_o=1, scrub_we_o=1, scrub_wdata_o = re-encoded corrected data; WRITE->word done on scrub_gnt_i.
REQ-015 Stale flag: set when func_we_i=1 and func_addr_i=addr_q while state is WAIT or WRITE (grant cycle included); stale in WAIT suppresses write-back (error still counted); stale in WRITE before grant drops request next cycle and completes word without write; cleared at word done.
REQ-016 Word done: addr_q increments; at NumWords-1 wraps to 0 and pulses pass_done_o for one cycle; interval counter reloads Interval; FSM returns to IDLE.
REQ-017 Counters SHALL saturate at all-ones; cnt_clear_i zeroes both; clear coincident with increment yields 1.
REQ-018 Outputs registered except scrub_* which are decoded from state and registered data; latency from grant to next READ with Interval=0 and no error SHALL be rvalid cycle + 1.

Reset
REQ-019 On rst_i: state IDLE, addr_q 0, interval counter 0, stale 0, all counters 0, double_addr_o 0, all pulses and scrub_req_o 0.
REQ-020 Reset mid-transaction SHALL abandon the access immediately; no write-back afterwards.

Structure
REQ-021 FSM state enum and AW derivation helper SHALL live in ecc_pkg; encoded word type reuses ecc_pkg widths.
REQ-022 SHALL instantiate existing ecc_decode and ecc_encode (DataWidth); no new sub-module.

Verification
REQ-023 NumWords=4, Interval=0, clean memory, enable_i=1 -> reads addr 0,1,2,3, no writes, pass_done_o pulse after addr 3, counters 0.
REQ-024 Addr 2 with data bit 5 flipped -> one write to addr 2 with correct codeword, single_cnt_o=1, double_cnt_o=0.
REQ-025 Addr 1 with two bits flipped -> no write, double_cnt_o=1, double_err_o single pulse, double_addr_o=1.
REQ-026 Single error at addr 3 plus func_we_i to addr 3 during WAIT -> no scrub write, single_cnt_o=1.
REQ-027 scrub_gnt_i held low 5 cycles with enable_i dropped in READ -> scrub_req_o stays 1 until grant, then word completes and FSM idles.
REQ-028 CntWidth=2, four single errors -> single_cnt_o saturates at 3; cnt_clear_i with coincident error -> 1.
